// File: rtl/m_antilogshifter32_seq_pkg.sv
// Shared log-path constants, antilog shifter state encoding and the shift
// amount helper used by the iterative stage.
package m_antilogshifter32_seq_pkg;

  localparam int LOG_WL_N = 32;
  localparam int LOG_WL_K = 5;
  localparam int LOG_WL_M = LOG_WL_N - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Stage weight for counter value c: bit c of K controls a 2**c shift.
  function automatic logic [31:0] shamt(input int unsigned c);
    return 32'd1 << c;
  endfunction

endpackage

// File: rtl/m_antilogshifter32_seq_rshift_stage.sv
// One binary-weighted logical right-shift stage; zero fill, no rounding.
module m_rshift_stage #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] sreg_i,
  input  logic [31:0]  amt,
  output logic [W-1:0] sreg_o
);

  assign sreg_o = en ? (sreg_i >> amt) : sreg_i;

endmodule

// File: rtl/m_antilogshifter32_seq.sv
// Iterative antilog shifter: N = {1, M} >> (wl_N-1-K), one weighted stage
// per clock, MSB weight first, with valid/ready on both sides.
module m_antilogshifter32_seq
  import m_antilogshifter32_seq_pkg::*;
#(
  parameter int wl_N = LOG_WL_N,
  parameter int wl_k = LOG_WL_K,
  parameter int wl_m = wl_N - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [wl_k-1:0] K,
  input  logic [wl_m-1:0] M,
  input  logic            Z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [wl_N-1:0] N
);

  localparam int CW = (wl_k > 1) ? $clog2(wl_k) : 1;

  logic [1:0]      state_q, state_d;
  logic [wl_N-1:0] sreg_q, sreg_d, sreg_nxt;
  logic [wl_k-1:0] kreg_q, kreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     amt;

  assign amt = shamt(int'(cnt_q));

  // A cleared K bit means that weight of the total shift (wl_N-1-K == ~K) applies.
  m_rshift_stage #(.W(wl_N)) u_stage (
    .en     (~kreg_q[cnt_q]),
    .sreg_i (sreg_q),
    .amt    (amt),
    .sreg_o (sreg_nxt)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sreg_d  = Z ? '0 : {1'b1, M};
          kreg_d  = K;
          cnt_d   = CW'(wl_k - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_nxt;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      kreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign N         = out_valid ? sreg_q : '0;

endmodule
